// File: rtl/adder_tree_norm_pkg.sv
// Shared width helpers for the signed mantissa adder tree and normaliser.
// Elaboration-time functions only; no hardware lives here.
package adder_tree_norm_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int calc_in_w(input int sig_w, input int low_exp);
    return sig_w + 4 + low_exp;
  endfunction

  function automatic int calc_sum_w(input int in_w, input int num_in);
    return in_w + clog2(num_in);
  endfunction

  // The offset spans p = 0 .. sum_w-1, shifted by the mantissa/fraction position.
  function automatic bit exp_range_ok(input int exp_w, input int sig_w,
                                      input int low_exp, input int sum_w);
    int lo;
    int hi;
    lo = -(sig_w - 1) - low_exp;
    hi = sum_w - 1 - (sig_w - 1) - low_exp;
    return (lo >= -(1 << (exp_w - 1))) && (hi <= (1 << (exp_w - 1)) - 1);
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((1 << clog2(n)) == n);
  endfunction

endpackage

// File: rtl/adder_tree_norm_pipe_lead_one_det.sv
// Priority encoder: index of the highest set bit plus an all-zero flag.
module lead_one_det
  import adder_tree_norm_pkg::*;
#(
  parameter int W = 12,
  localparam int IW = clog2(W)
) (
  input  logic [W-1:0]  i_vec,
  output logic [IW-1:0] o_idx,
  output logic          o_zero
);

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < W; i++) begin
      if (i_vec[i]) o_idx = IW'(i);
    end
  end

  assign o_zero = ~|i_vec;

endmodule

// File: rtl/adder_tree_norm_pipe.sv
// Pipelined NUM_IN-lane signed mantissa adder tree with leading-one normalisation.
// Build option ROUND_RNE_EN: round-to-nearest-even in the output stage (default truncates).
module adder_tree_norm_pipe
  import adder_tree_norm_pkg::*;
#(
  parameter int EXP_WIDTH  = 4,
  parameter int SIG_WIDTH  = 4,
  parameter int LOW_EXPAND = 2,
  parameter int NUM_IN     = 4,
  localparam int IN_W      = calc_in_w(SIG_WIDTH, LOW_EXPAND)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  input  logic [NUM_IN*IN_W-1:0]      i_man_in,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic                        o_sign,
  output logic [SIG_WIDTH-1:0]        o_mantissa,
  output logic signed [EXP_WIDTH-1:0] o_exp_offset,
  output logic                        o_zero
);

  localparam int LVL   = clog2(NUM_IN);
  localparam int SUM_W = calc_sum_w(IN_W, NUM_IN);
  localparam int PW    = clog2(SUM_W);
  localparam int XW    = SUM_W + SIG_WIDTH;

  if (!exp_range_ok(EXP_WIDTH, SIG_WIDTH, LOW_EXPAND, SUM_W)) begin : g_bad_exp
    $error("EXP_WIDTH too narrow for the exponent offset range");
  end
  if (!is_pow2(NUM_IN)) begin : g_bad_num_in
    $error("NUM_IN must be a power of two and at least 2");
  end

  logic w_en;
  assign w_en       = ~o_out_valid | i_out_ready;
  assign o_in_ready = w_en;

  // Heap layout: node n sums children 2n and 2n+1; leaves NUM_IN.. are the lanes.
  logic signed [SUM_W-1:0] w_node [2:2*NUM_IN-1];
  logic signed [SUM_W-1:0] r_node [1:NUM_IN-1];
  logic [LVL-1:0]          r_tvld;

  always_comb begin
    for (int n = 2; n < NUM_IN; n++) w_node[n] = r_node[n];
    for (int k = 0; k < NUM_IN; k++)
      w_node[NUM_IN+k] = SUM_W'($signed(i_man_in[k*IN_W +: IN_W]));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_tvld <= '0;
    else if (w_en) r_tvld <= LVL'({r_tvld, i_in_valid});
  end

  always_ff @(posedge i_clk) begin
    if (w_en) begin
      for (int n = 1; n < NUM_IN; n++) r_node[n] <= w_node[2*n] + w_node[2*n+1];
    end
  end

  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] w_mag;
  logic [PW-1:0]    w_p;
  logic             w_zero;
  assign w_sum = r_node[1];
  assign w_mag = w_sum[SUM_W-1] ? -w_sum : w_sum;

  lead_one_det #(.W(SUM_W)) u_lod (
    .i_vec  (w_mag),
    .o_idx  (w_p),
    .o_zero (w_zero)
  );

  logic [SUM_W-1:0] r_mag;
  logic [PW-1:0]    r_p;
  logic             r_sign;
  logic             r_zero;
  logic             r_v1;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_v1 <= 1'b0;
    else if (w_en) r_v1 <= r_tvld[LVL-1];
  end

  always_ff @(posedge i_clk) begin
    if (w_en) begin
      r_mag  <= w_mag;
      r_p    <= w_p;
      r_sign <= w_sum[SUM_W-1];
      r_zero <= w_zero;
    end
  end

  // Zero-fill below bit 0 by appending SIG_WIDTH zeros before shifting.
  logic [XW-1:0]               w_ext;
  logic [XW-1:0]               w_shift;
  logic [SIG_WIDTH-1:0]        w_mant_t;
  logic signed [EXP_WIDTH-1:0] w_exp_t;
  logic [SIG_WIDTH-1:0]        w_mant;
  logic signed [EXP_WIDTH-1:0] w_exp;

  assign w_ext    = {r_mag, {SIG_WIDTH{1'b0}}};
  assign w_shift  = w_ext >> r_p;
  assign w_mant_t = SIG_WIDTH'(w_shift >> 1);
  assign w_exp_t  = EXP_WIDTH'(int'(r_p) - (SIG_WIDTH - 1) - LOW_EXPAND);

`ifdef ROUND_RNE_EN
  logic               w_guard;
  logic               w_sticky;
  logic               w_inc;
  logic [SIG_WIDTH:0] w_rnd;

  assign w_guard  = w_shift[0];
  assign w_sticky = |(w_ext & ~({XW{1'b1}} << r_p));
  assign w_inc    = w_guard & (w_sticky | w_mant_t[0]);
  assign w_rnd    = {1'b0, w_mant_t} + (SIG_WIDTH+1)'(w_inc);
  assign w_mant   = w_rnd[SIG_WIDTH] ? {1'b1, {(SIG_WIDTH-1){1'b0}}} : w_rnd[SIG_WIDTH-1:0];
  assign w_exp    = w_rnd[SIG_WIDTH] ? w_exp_t + EXP_WIDTH'(1) : w_exp_t;
`else
  assign w_mant = w_mant_t;
  assign w_exp  = w_exp_t;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_out_valid  <= 1'b0;
      o_sign       <= 1'b0;
      o_mantissa   <= '0;
      o_exp_offset <= '0;
      o_zero       <= 1'b0;
    end else if (w_en) begin
      o_out_valid <= r_v1;
      if (r_v1) begin
        o_zero       <= r_zero;
        o_sign       <= r_zero ? 1'b0 : r_sign;
        o_mantissa   <= r_zero ? '0 : w_mant;
        o_exp_offset <= r_zero ? '0 : w_exp;
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_norm_pipe.sv
// Randomised bench for adder_tree_norm_pipe with an arithmetic reference model and scoreboard.
module tb_adder_tree_norm_pipe;
  localparam int EXPW = 4;
  localparam int SIG  = 4;
  localparam int LOW  = 2;
  localparam int NIN  = 4;
  localparam int INW  = SIG + 4 + LOW;

  logic              clk = 1'b0;
  logic              i_rst, i_in_valid, o_in_ready, o_out_valid, i_out_ready;
  logic [NIN*INW-1:0] i_man_in;
  logic              o_sign, o_zero;
  logic [SIG-1:0]    o_mantissa;
  logic signed [EXPW-1:0] o_exp_offset;

  int n_chk = 0;
  int n_err = 0;
  int n_out = 0;
  int rdy_mode = 0;
  logic [9:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [9:0] prev_out = '0;

  always #5 clk = ~clk;

  adder_tree_norm_pipe #(.EXP_WIDTH(EXPW), .SIG_WIDTH(SIG), .LOW_EXPAND(LOW), .NUM_IN(NIN)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_man_in(i_man_in), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_sign(o_sign), .o_mantissa(o_mantissa), .o_exp_offset(o_exp_offset), .o_zero(o_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, expv, $time);
    end
  endtask

  // Result packed as {sign, zero, mantissa, exp_offset}.
  function automatic logic [9:0] model(input logic [NIN*INW-1:0] v);
    int s, mag, p, m, e;
    logic signed [INW-1:0] t;
    s = 0;
    for (int k = 0; k < NIN; k++) begin
      t = v[k*INW +: INW];
      s += int'(t);
    end
    mag = (s < 0) ? -s : s;
    if (mag == 0) return {1'b0, 1'b1, 4'b0, 4'b0};
    p = 0;
    for (int b = 0; b < 16; b++) if (mag >= (1 << b)) p = b;
    if (p >= SIG - 1) m = mag >> (p - SIG + 1);
    else m = mag << (SIG - 1 - p);
    e = p - (SIG - 1) - LOW;
`ifdef ROUND_RNE_EN
    if (p >= SIG) begin
      int rem, half;
      rem  = mag % (1 << (p - SIG + 1));
      half = 1 << (p - SIG);
      if (rem > half || (rem == half && (m % 2) == 1)) m++;
      if (m == (1 << SIG)) begin
        m = 1 << (SIG - 1);
        e++;
      end
    end
`endif
    return {(s < 0), 1'b0, 4'(m), 4'(e)};
  endfunction

  function automatic logic [NIN*INW-1:0] pack(input int a, input int b, input int c, input int d);
    return {10'(d), 10'(c), 10'(b), 10'(a)};
  endfunction

  wire [9:0] cur = {o_sign, o_zero, o_mantissa, o_exp_offset};

  always @(negedge clk) begin
    if (i_rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_rule", o_in_ready, !o_out_valid || i_out_ready);
      if (prev_stall) begin
        chk("hold_valid", o_out_valid, 1);
        chk("hold_data", cur, prev_out);
      end
      if (i_in_valid && o_in_ready) exp_q.push_back(model(i_man_in));
      if (o_out_valid && i_out_ready) begin
        if (exp_q.size() == 0) chk("stale_output", o_out_valid, 0);
        else begin
          chk("result", cur, exp_q.pop_front());
          n_out++;
        end
      end
      prev_stall = o_out_valid && !i_out_ready;
      prev_out   = cur;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) i_out_ready = ($urandom_range(0, 9) < 7);
  end

  task automatic send_beat(input logic [NIN*INW-1:0] v);
    logic took;
    int guard;
    i_man_in = v;
    i_in_valid = 1'b1;
    guard = 0;
    took = 1'b0;
    do begin
      @(negedge clk);
      took = o_in_ready;
      @(posedge clk); #1;
      guard++;
    end while (!took && guard < 200);
    if (!took) chk("send_timeout", 32'(took), 1);
    i_in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || o_out_valid) && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  task automatic latency_check(input logic [NIN*INW-1:0] v);
    int n;
    i_man_in = v;
    i_in_valid = 1'b1;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    n = 1;
    while (!o_out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 4);
  endtask

  function automatic logic [NIN*INW-1:0] rand_beat();
    logic [NIN*INW-1:0] v;
    int sel;
    sel = $urandom_range(0, 7);
    for (int k = 0; k < NIN; k++) begin
      if (sel == 0) v[k*INW +: INW] = '0;
      else if (sel < 4) v[k*INW +: INW] = 10'($urandom_range(0, 63) - 32);
      else v[k*INW +: INW] = 10'($urandom_range(0, 1023));
    end
    return v;
  endfunction

  initial begin
    #300000;
    $display("FAIL global_timeout reached at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int n0;
    i_rst = 1'b1; i_in_valid = 1'b0; i_man_in = '0; i_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_sign", o_sign, 0);
    chk("rst_mantissa", o_mantissa, 0);
    chk("rst_exp", o_exp_offset, 0);
    chk("rst_zero", o_zero, 0);
    i_rst = 1'b0;

    send_beat(pack(16, 0, 0, 0));
    send_beat(pack(16, -20, 0, 0));
    send_beat(pack(-512, -512, -512, -512));
    send_beat(pack(0, 0, 0, 0));
    send_beat(pack(31, 0, 0, 0));
    send_beat(pack(1, 0, 0, 0));
    send_beat(pack(511, 511, 511, 511));
    send_beat(pack(-3, 2, 0, 1));
    drain();
    latency_check(pack(16, 0, 0, 0));
    drain();

    rdy_mode = 2;
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) send_beat(pack(i * 7 + 3, -i, 2 * i, 1));
      end
      begin
        repeat (6) @(posedge clk);
        #1 i_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 i_out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", n_out - n0, 8);

    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send_beat(rand_beat());
    end
    rdy_mode = 0;
    #1 i_out_ready = 1'b1;
    drain();

    for (int i = 0; i < 3; i++) send_beat(rand_beat());
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    chk("rst_flush_valid", o_out_valid, 0);
    repeat (5) begin
      @(posedge clk); #1;
      chk("no_stale_after_rst", o_out_valid, 0);
    end
    latency_check(pack(-100, 37, 5, 0));
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
